// File: rtl/rom_loader.sv
// Byte-stream ROM programmer: length, little-endian words, 8-bit checksum; holds the core in reset until verified.
// Optional inter-byte idle timeout enabled by defining ROM_LOADER_TIMEOUT_EN.
//
// state  | meaning
// S_LEN0 | waiting for low byte of word count
// S_LEN1 | waiting for high byte of word count
// S_DATA | assembling data bytes into 32-bit words
// S_CSUM | waiting for checksum byte
// S_DONE | image loaded and verified, core released
// S_ERR  | frame error, core held in reset
module rom_loader #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state, state_nx;
  logic                xfer;
  logic                timeout;
  logic                rearm;
  logic [7:0]          len_lo;
  logic [7:0]          sum;
  logic [15:0]         words_left;
  logic [1:0]          byte_idx;
  logic [23:0]         wbuf;
  logic [ADDR_W-1:0]   widx;
  logic [16:0]         count_in;

  assign xfer     = in_valid && in_ready;
  assign rearm    = restart && (state == S_DONE || state == S_ERR);
  assign count_in = {1'b0, in_data, len_lo};

`ifdef ROM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  // Down-counter reloaded on every byte; terminal count on an idle cycle trips the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= TW'(TIMEOUT_CYC - 1);
    end else if (state == S_LEN0 || xfer) begin
      idle_cnt <= TW'(TIMEOUT_CYC - 1);
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  assign timeout = (state == S_LEN1 || state == S_DATA || state == S_CSUM) &&
                   !xfer && (idle_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LEN0: if (xfer) state_nx = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (count_in > 17'(DEPTH))   state_nx = S_ERR;
          else if (count_in == 17'd0)  state_nx = S_CSUM;
          else                         state_nx = S_DATA;
        end else if (timeout) begin
          state_nx = S_ERR;
        end
      end
      S_DATA: begin
        if (xfer && byte_idx == 2'd3 && words_left == 16'd1) state_nx = S_CSUM;
        else if (timeout)                                    state_nx = S_ERR;
      end
      S_CSUM: begin
        if (xfer)         state_nx = (in_data == sum) ? S_DONE : S_ERR;
        else if (timeout) state_nx = S_ERR;
      end
      S_DONE, S_ERR: if (restart) state_nx = S_LEN0;
      default: state_nx = S_LEN0;
    endcase
  end

  // Status outputs are registered from the next state so they track the FSM with no extra lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      sum        <= '0;
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      wbuf       <= '0;
      widx       <= '0;
    end else begin
      in_ready  <= (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
                   (state_nx == S_DATA) || (state_nx == S_CSUM);
      done      <= (state_nx == S_DONE);
      err       <= (state_nx == S_ERR);
      core_hold <= (state_nx != S_DONE);
      rom_we    <= 1'b0;
      if (rearm) begin
        sum      <= '0;
        widx     <= '0;
        byte_idx <= '0;
      end else if (xfer) begin
        if (state != S_CSUM) sum <= sum + in_data;
        case (state)
          S_LEN0: len_lo <= in_data;
          S_LEN1: begin
            words_left <= count_in[15:0];
            byte_idx   <= '0;
            widx       <= '0;
          end
          S_DATA: begin
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: wbuf[7:0]   <= in_data;
              2'd1: wbuf[15:8]  <= in_data;
              2'd2: wbuf[23:16] <= in_data;
              default: begin
                rom_we     <= 1'b1;
                rom_wdata  <= {in_data, wbuf};
                rom_waddr  <= widx;
                widx       <= widx + 1'b1;
                words_left <= words_left - 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected ROM writes are queued as frames are sent and popped on rom_we.
module tb_rom_loader;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              restart = 1'b0;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  rom_loader #(.ADDR_W(ADDR_W), .DEPTH(4096), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_exp    = 0;
  logic [43:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [43:0] item;
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        item = sb.pop_front();
        check("waddr", {20'b0, rom_waddr}, {20'b0, item[43:32]});
        check("wdata", rom_wdata, item[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [7:0] cx);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'(n) + 8'(n >> 8);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      sb.push_back({12'(i), w});
      n_exp++;
      for (int k = 0; k < 4; k++) begin
        s = s + w[8*k +: 8];
        send_byte(w[8*k +: 8]);
      end
    end
    send_byte(s ^ cx);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_core_hold", {31'b0, core_hold}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rom_we", {31'b0, rom_we}, 32'd0);
    check("rst_waddr", {20'b0, rom_waddr}, 32'd0);
    check("rst_wdata", rom_wdata, 32'd0);

    // Good two-word frame, checksum 0x84
    send_frame(2, 32'h0000_0013, 32'h0000_006F, 8'h00);
    check("good_done", {31'b0, done}, 32'd1);
    check("good_core_hold", {31'b0, core_hold}, 32'd0);
    check("good_err", {31'b0, err}, 32'd0);
    check("good_in_ready", {31'b0, in_ready}, 32'd0);

    // Bad checksum 0x85: writes still happen, ends in error
    pulse_restart();
    check("restart_done", {31'b0, done}, 32'd0);
    check("restart_core_hold", {31'b0, core_hold}, 32'd1);
    send_frame(2, 32'h0000_0013, 32'h0000_006F, 8'h01);
    check("badcs_err", {31'b0, err}, 32'd1);
    check("badcs_done", {31'b0, done}, 32'd0);
    check("badcs_core_hold", {31'b0, core_hold}, 32'd1);
    check("badcs_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("err_holds", {31'b0, err}, 32'd1);

    // Oversized count 0x1001
    pulse_restart();
    check("restart_err", {31'b0, err}, 32'd0);
    check("restart_in_ready", {31'b0, in_ready}, 32'd1);
    send_byte(8'h01);
    check("len_mid_err", {31'b0, err}, 32'd0);
    send_byte(8'h10);
    check("oversize_err", {31'b0, err}, 32'd1);
    check("oversize_in_ready", {31'b0, in_ready}, 32'd0);

    // Zero-length frame
    pulse_restart();
    send_frame(0, 32'h0, 32'h0, 8'h00);
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_err", {31'b0, err}, 32'd0);

    // Reset mid-word, then a fresh one-word frame
    pulse_restart();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_core_hold", {31'b0, core_hold}, 32'd1);
    send_frame(1, 32'hDDCC_BBAA, 32'h0, 8'h00);
    check("after_abort_done", {31'b0, done}, 32'd1);
    check("after_abort_core_hold", {31'b0, core_hold}, 32'd0);

    pulse_restart();
    send_byte(8'h01);
    send_byte(8'h00);
`ifdef ROM_LOADER_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("timeout_early", {31'b0, err}, 32'd0);
    @(negedge clk);
    check("timeout_err", {31'b0, err}, 32'd1);
    check("timeout_in_ready", {31'b0, in_ready}, 32'd0);
    pulse_restart();
    check("to_restart_err", {31'b0, err}, 32'd0);
    check("to_restart_core_hold", {31'b0, core_hold}, 32'd1);
    check("to_restart_in_ready", {31'b0, in_ready}, 32'd1);
`else
    repeat (40) @(negedge clk);
    check("no_timeout_err", {31'b0, err}, 32'd0);
    check("no_timeout_in_ready", {31'b0, in_ready}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("write_count", n_writes, n_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
